// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// The default operand width matches the sequential divider.
package seq_multiplier_pkg;

  localparam int DEF_W = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier, one multiplier bit per clock.
// Result arrives W clocks after an accepted start, with a one-cycle done strobe.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int CW = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] opt
);

  generate
    if ((1 << CW) <= W) begin : g_cw_check
      $error("CW too narrow for W");
    end
  endgenerate

  state_t         state;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] sum;

  // mcand is zero-extended at capture, so the sum never exceeds 2W bits.
  assign sum = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      opt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= {{W{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= CW'(W);
            state  <= ST_RUN;
            busy   <= 1'b1;
          end
        end
        ST_RUN: begin
          done   <= 1'b0;
          acc    <= sum;
          mcand  <= {mcand[2*W-2:0], 1'b0};
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          // Last iteration: publish the sum including this step's add.
          if (cnt == CW'(1)) begin
            opt   <= sum;
            done  <= 1'b1;
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: latency-countdown reference model checked every cycle,
// directed scenarios with literal expectations, exhaustive sweep and random traffic.
module tb_seq_multiplier;

  localparam int W = 5;

  logic           clk;
  logic           reset;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] opt;

  seq_multiplier #(.W(W), .CW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .opt   (opt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: an operation is just "product pending, N edges to go".
  bit             armed = 1'b0;
  int             rem = 0;
  logic [2*W-1:0] pend = '0;
  logic [2*W-1:0] exp_opt = '0;
  logic           exp_done = 1'b0;
  logic           exp_busy = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      armed    = 1'b1;
      rem      = 0;
      exp_opt  = '0;
      exp_done = 1'b0;
    end else if (armed) begin
      exp_done = 1'b0;
      if (rem == 0) begin
        if (start) begin
          pend = (2*W)'(a) * (2*W)'(b);
          rem  = W;
        end
      end else begin
        rem--;
        if (rem == 0) begin
          exp_opt  = pend;
          exp_done = 1'b1;
        end
      end
    end
    exp_busy = (rem != 0);
  end

  always @(negedge clk) begin
    if (armed) begin
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      check("opt",  32'(opt),  32'(exp_opt));
    end
  end

  // Drive one start pulse, then count edges until done; lat = edges after acceptance.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, output int lat);
    start = 1'b1; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout waiting for done (a=%0d b=%0d)", av, bv);
    end
  endtask

  task automatic count_dones(input int cycles, output int nd);
    nd = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
  endtask

  initial begin
    int lat, nd, d;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    @(negedge clk);
    reset = 1'b0;
    check("reset_opt", 32'(opt), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    @(negedge clk);

    // Basic 7*5
    run_op(5'd7, 5'd5, lat);
    check("basic_lat", lat, 5);
    check("basic_opt", 32'(opt), 32'h023);
    count_dones(4, nd);
    check("basic_single_done", nd, 0);
    check("basic_hold", 32'(opt), 35);

    // Extremes
    run_op(5'd31, 5'd31, lat);
    check("max_lat", lat, 5);
    check("max_opt", 32'(opt), 32'h3C1);
    @(negedge clk);
    run_op(5'd0, 5'd19, lat);
    check("zero_lat", lat, 5);
    check("zero_opt", 32'(opt), 0);
    @(negedge clk);

    // Start while busy is ignored
    start = 1'b1; a = 5'd3; b = 5'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 5'd9; b = 5'd9;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("busy_ign_opt", 32'(opt), 12);
    count_dones(10, nd);
    check("busy_ign_no_second", nd, 0);

    // Back-to-back: new start in the done cycle
    run_op(5'd7, 5'd5, lat);
    start = 1'b1; a = 5'd6; b = 5'd7;
    @(negedge clk);
    start = 1'b0;
    d = 1;
    while (!done && d < 40) begin
      @(negedge clk);
      d++;
    end
    check("b2b_spacing", d, 6);
    check("b2b_opt", 32'(opt), 42);
    @(negedge clk);

    // Reset mid-operation
    start = 1'b1; a = 5'd10; b = 5'd10;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_done", 32'(done), 0);
    check("rst_mid_opt", 32'(opt), 0);
    count_dones(10, nd);
    check("rst_mid_no_done", nd, 0);
    run_op(5'd2, 5'd3, lat);
    check("after_rst_opt", 32'(opt), 6);
    check("after_rst_lat", lat, 5);

    // Divider cross-check: 7 / 5 -> q=1, r=2
    run_op(5'd1, 5'd5, lat);
    check("div_xcheck", 32'(opt) + 32'd2, 7);

    // Exhaustive sweep, back-to-back
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 32; j++) begin
        run_op(5'(i), 5'(j), lat);
        check("sweep", 32'(opt), 32'(i * j));
      end
    end

    // Random traffic with occasional resets; the model checks every cycle
    for (int k = 0; k < 3000; k++) begin
      start = ($urandom_range(0, 2) == 0);
      a     = 5'($urandom);
      b     = 5'($urandom);
      reset = ($urandom_range(0, 149) == 0);
      @(negedge clk);
    end
    start = 1'b0; reset = 1'b0;
    repeat (8) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
